// File: rtl/fwrisc_regfile_arb_pkg.sv
// Shared types and default geometry for the fwrisc register-file access controller.
`timescale 1ns/1ps
package fwrisc_regfile_arb_pkg;

  localparam int unsigned NREGS_DEF      = 64;
  localparam int unsigned AW_DEF         = 6;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned STARVE_MAX_DEF = 16;
  localparam int unsigned STARVE_CW      = 8;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/fwrisc_regfile_arb.sv
// Zero-fills the register file after reset, then shares its write port and read
// port B between the core (fixed priority) and a debug host with a starvation guard.
`timescale 1ns/1ps
module fwrisc_regfile_arb
  import fwrisc_regfile_arb_pkg::*;
#(
  parameter int unsigned NREGS      = NREGS_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,

  output logic          init_done,
  output logic          core_stall,

  input  logic [AW-1:0] core_ra_raddr,
  input  logic [AW-1:0] core_rb_raddr,
  input  logic          core_rb_req,
  input  logic [AW-1:0] core_rd_waddr,
  input  logic [DW-1:0] core_rd_wdata,
  input  logic          core_rd_wen,
  output logic [DW-1:0] core_ra_rdata,
  output logic [DW-1:0] core_rb_rdata,

  input  logic          dbg_req_valid,
  output logic          dbg_req_ready,
  input  logic          dbg_req_we,
  input  logic [AW-1:0] dbg_req_addr,
  input  logic [DW-1:0] dbg_req_wdata,
  output logic          dbg_rsp_valid,
  output logic [DW-1:0] dbg_rsp_rdata,

  output logic [AW-1:0] rf_ra_raddr,
  output logic [AW-1:0] rf_rb_raddr,
  output logic [AW-1:0] rf_rd_waddr,
  output logic [DW-1:0] rf_rd_wdata,
  output logic          rf_rd_wen,
  input  logic [DW-1:0] rf_ra_rdata,
  input  logic [DW-1:0] rf_rb_rdata
);

  localparam logic [AW-1:0]        FILL_LAST  = AW'(NREGS - 1);
  localparam logic [STARVE_CW-1:0] STARVE_LIM = STARVE_CW'(STARVE_MAX);

  state_e               state_q, state_d;
  logic [AW-1:0]        fill_q;
  logic [STARVE_CW-1:0] starve_q;
  logic                 rsp_valid_q;

  logic run;
  logic forced;
  logic host_wr_grant;
  logic host_rd_grant;
  logic xfer;
  logic host_wr;
  logic host_rd;

  // Arbitration is purely combinational; no host request is ever held here.
  assign run           = (state_q == RUN);
  assign forced        = run && (starve_q == STARVE_LIM);
  assign host_wr_grant = !core_rd_wen || forced;
  assign host_rd_grant = !core_rb_req || forced;
  assign dbg_req_ready = run && dbg_req_valid &&
                         (dbg_req_we ? host_wr_grant : host_rd_grant);
  assign xfer          = dbg_req_valid && dbg_req_ready;
  assign host_wr       = xfer && dbg_req_we;
  assign host_rd       = xfer && !dbg_req_we;

  assign rf_ra_raddr   = core_ra_raddr;
  assign core_ra_rdata = rf_ra_rdata;
  assign rf_rb_raddr   = host_rd ? dbg_req_addr : core_rb_raddr;
  assign core_rb_rdata = rf_rb_rdata;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rf_rb_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    init_done   = 1'b0;
    core_stall  = 1'b1;
    rf_rd_wen   = 1'b1;
    rf_rd_waddr = fill_q;
    rf_rd_wdata = '0;
    unique case (state_q)
      INIT: begin
        if (fill_q == FILL_LAST) state_d = RUN;
      end
      RUN: begin
        init_done  = 1'b1;
        core_stall = forced;
        if (host_wr) begin
          rf_rd_waddr = dbg_req_addr;
          rf_rd_wdata = dbg_req_wdata;
        end else begin
          // A forced cycle stalls the core, so its write must not land.
          rf_rd_waddr = core_rd_waddr;
          rf_rd_wdata = core_rd_wdata;
          rf_rd_wen   = core_rd_wen && !forced;
        end
      end
    endcase
  end

  // NOTE: the storage itself has no reset; this counter walks every entry
  // writing zero so software sees a defined file after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
    end else if (state_q == INIT) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  // Counts host wait cycles in RUN; reaching the limit forces a grant, which
  // clears it again, so it never passes STARVE_LIM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!run || !dbg_req_valid || xfer) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= host_rd;
    end
  end

endmodule

// File: tb/tb_fwrisc_regfile_arb.sv
// Scoreboard bench: a behavioural register file model behind the arbiter, host
// read expectations queued at acceptance and checked by an independent monitor.
`timescale 1ns/1ps
module tb_fwrisc_regfile_arb;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NREGS = 64;
  localparam int STARVE_MAX = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_done, core_stall;
  logic [AW-1:0] core_ra_raddr = '0, core_rb_raddr = '0, core_rd_waddr = '0;
  logic          core_rb_req = 1'b0, core_rd_wen = 1'b0;
  logic [DW-1:0] core_rd_wdata = '0;
  logic [DW-1:0] core_ra_rdata, core_rb_rdata;
  logic          dbg_req_valid = 1'b0, dbg_req_we = 1'b0;
  logic          dbg_req_ready, dbg_rsp_valid;
  logic [AW-1:0] dbg_req_addr = '0;
  logic [DW-1:0] dbg_req_wdata = '0, dbg_rsp_rdata;
  logic [AW-1:0] rf_ra_raddr, rf_rb_raddr, rf_rd_waddr;
  logic [DW-1:0] rf_rd_wdata, rf_ra_rdata, rf_rb_rdata;
  logic          rf_rd_wen;

  fwrisc_regfile_arb #(
    .NREGS(NREGS), .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .init_done(init_done), .core_stall(core_stall),
    .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
    .core_rb_req(core_rb_req), .core_rd_waddr(core_rd_waddr),
    .core_rd_wdata(core_rd_wdata), .core_rd_wen(core_rd_wen),
    .core_ra_rdata(core_ra_rdata), .core_rb_rdata(core_rb_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_ra_raddr(rf_ra_raddr), .rf_rb_raddr(rf_rb_raddr),
    .rf_rd_waddr(rf_rd_waddr), .rf_rd_wdata(rf_rd_wdata),
    .rf_rd_wen(rf_rd_wen), .rf_ra_rdata(rf_ra_rdata), .rf_rb_rdata(rf_rb_rdata)
  );

  always #5 clock = ~clock;

  // Register file: no reset (starts as garbage), registered read address, x0 reads 0.
  logic [DW-1:0] mem [NREGS] = '{default: 32'hBAD0_BAD0};
  logic [AW-1:0] ra_q = '0, rb_q = '0;
  always @(posedge clock) begin
    if (rf_rd_wen && rf_rd_waddr != '0) mem[rf_rd_waddr] <= rf_rd_wdata;
    ra_q <= rf_ra_raddr;
    rb_q <= rf_rb_raddr;
  end
  assign rf_ra_rdata = (ra_q == '0) ? '0 : mem[ra_q];
  assign rf_rb_rdata = (rb_q == '0) ? '0 : mem[rb_q];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clock) begin : monitor
    exp_t e;
    if (dbg_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got response %h, required no response", dbg_rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", dbg_rsp_rdata, e.data);
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic host_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                          output int waits, output logic stall_at_accept);
    bit acc = 1'b0;
    waits = 0;
    stall_at_accept = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_we    = we;
    dbg_req_addr  = addr;
    dbg_req_wdata = wdata;
    while (!acc && waits <= 100) begin
      @(negedge clock);
      if (dbg_req_ready === 1'b1) acc = 1'b1;
      else begin
        waits++;
        @(posedge clock); #1;
      end
    end
    if (!acc) begin
      total++;
      $display("FAIL host_req_timeout: got no ready in %0d cycles, required ready", waits);
      dbg_req_valid = 1'b0;
      return;
    end
    stall_at_accept = core_stall;
    if (!we) exp_q.push_back('{data: exp_rdata, due: cyc + 1});
    @(posedge clock); #1;
    dbg_req_valid = 1'b0;
  endtask

  task automatic host_write_idle(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w;
    logic st;
    host_req(1'b1, addr, data, '0, w, st);
    check($sformatf("wr_ready_wait_x%0d", addr), 32'(w), 0);
  endtask

  task automatic host_read_idle(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int w;
    logic st;
    host_req(1'b0, addr, '0, exp, w, st);
    check($sformatf("rd_ready_wait_x%0d", addr), 32'(w), 0);
  endtask

  // Called at posedge+1 right after reset release; checks n fill cycles.
  task automatic fill_run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check($sformatf("fill_%0d", k), {24'b0, init_done, rf_rd_wen, rf_rd_waddr},
            {24'b0, 1'b0, 1'b1, 6'(k)});
      @(posedge clock); #1;
    end
  endtask

  task automatic expect_init_done();
    @(negedge clock);
    check("init_done_at_64", {31'b0, init_done}, 1);
    check("stall_after_init", {31'b0, core_stall}, 0);
    @(posedge clock); #1;
  endtask

  int   w;
  logic st;

  initial begin
    // Reset state, with a host request pending that must not be accepted.
    dbg_req_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_init_done", {31'b0, init_done}, 0);
    check("rst_core_stall", {31'b0, core_stall}, 1);
    check("rst_ready", {31'b0, dbg_req_ready}, 0);
    check("rst_rsp_valid", {31'b0, dbg_rsp_valid}, 0);
    check("rst_fill_port", {rf_rd_wen, rf_rd_waddr, rf_rd_wdata[24:0]}, {1'b1, 6'd0, 25'd0});
    dbg_req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    fill_run(NREGS);
    expect_init_done();

    // Whole file reads back zero after the fill.
    for (int i = 0; i < NREGS; i++) host_read_idle(6'(i), 32'h0);

    // Host write then read, core idle; read-A path shows the same data.
    host_write_idle(6'd5, 32'hDEADBEEF);
    host_read_idle(6'd5, 32'hDEADBEEF);
    core_ra_raddr = 6'd5;
    @(posedge clock);
    @(negedge clock);
    check("core_ra_x5", core_ra_rdata, 32'hDEADBEEF);
    @(posedge clock); #1;
    host_write_idle(6'd0, 32'hFFFFFFFF);
    host_read_idle(6'd0, 32'h0);

    // Starvation: core writes x12 for 16 cycles, then x13 in the forced cycle.
    fork
      host_req(1'b1, 6'd11, 32'h5A5A5A5A, '0, w, st);
      begin
        core_rd_wen = 1'b1; core_rd_waddr = 6'd12; core_rd_wdata = 32'h1111;
        repeat (16) begin @(posedge clock); #1; end
        core_rd_waddr = 6'd13; core_rd_wdata = 32'h2222;
        @(posedge clock); #1;
        core_rd_wen = 1'b0;
      end
    join
    check("starve_waits", 32'(w), 16);
    check("starve_stall", {31'b0, st}, 1);
    host_read_idle(6'd11, 32'h5A5A5A5A);
    host_read_idle(6'd12, 32'h1111);
    host_read_idle(6'd13, 32'h0);

    // Same-address collision: core wins, host lands on the next idle cycle.
    fork
      host_req(1'b1, 6'd7, 32'h22, '0, w, st);
      begin
        core_rd_wen = 1'b1; core_rd_waddr = 6'd7; core_rd_wdata = 32'h11;
        @(negedge clock);
        check("collide_ready", {31'b0, dbg_req_ready}, 0);
        @(posedge clock); #1;
        core_rd_wen = 1'b0;
        @(negedge clock);
        check("collide_x7_core", mem[7], 32'h11);
      end
    join
    check("collide_waits", 32'(w), 1);
    host_read_idle(6'd7, 32'h22);

    // Back-to-back reads, one response per cycle.
    host_write_idle(6'd1, 32'd1);
    host_write_idle(6'd2, 32'd2);
    host_write_idle(6'd3, 32'd3);
    host_read_idle(6'd1, 32'd1);
    host_read_idle(6'd2, 32'd2);
    host_read_idle(6'd3, 32'd3);

    // Core holds read port B for 3 cycles; host read waits.
    fork
      host_req(1'b0, 6'd5, '0, 32'hDEADBEEF, w, st);
      begin
        core_rb_req = 1'b1; core_rb_raddr = 6'd1;
        @(posedge clock);
        @(negedge clock);
        check("core_rb_x1", core_rb_rdata, 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        core_rb_req = 1'b0;
      end
    join
    check("rb_contend_waits", 32'(w), 3);

    // Reset with a response pending drops it.
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 6'd2;
    @(negedge clock);
    check("midread_ready", {31'b0, dbg_req_ready}, 1);
    @(posedge clock); #1;
    dbg_req_valid = 1'b0;
    check("midread_rsp_pending", {31'b0, dbg_rsp_valid}, 1);
    reset = 1'b1;
    #1;
    check("midread_rsp_dropped", {31'b0, dbg_rsp_valid}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset mid-fill restarts from entry 0.
    fill_run(20);
    @(negedge clock);
    check("midfill_at_20", {26'b0, rf_rd_waddr}, 20);
    reset = 1'b1;
    #1;
    check("midfill_reset_addr", {26'b0, rf_rd_waddr}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    fill_run(NREGS);
    expect_init_done();

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fwrisc_regfile_arb.md
# fwrisc_regfile_arb

Access controller for the 64x32 two-read/one-write register file. After reset it runs a zero-fill sequence over every entry, since the storage has no reset. It then shares the file's write port and read port B between the fwrisc core and a debug/UART host port. The core has fixed priority; a starvation counter guarantees the host forward progress by stalling the core for one cycle.

## Interface
Parameters:
- NREGS, 64, number of register entries (power of two)
- AW, 6, address width, log2(NREGS)
- DW, 32, data width
- STARVE_MAX, 16, host wait cycles before a forced grant (2..255)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- init_done  out  1  zero-fill complete
- core_stall  out  1  core must hold state this cycle
- core_ra_raddr  in  AW  core read-A address
- core_rb_raddr  in  AW  core read-B address
- core_rb_req  in  1  core needs read port B this cycle
- core_rd_waddr  in  AW  core write address
- core_rd_wdata  in  DW  core write data
- core_rd_wen  in  1  core write enable
- core_ra_rdata  out  DW  read-A data to core
- core_rb_rdata  out  DW  read-B data to core
- dbg_req_valid  in  1  host request valid
- dbg_req_ready  out  1  host request accepted
- dbg_req_we  in  1  1 = write, 0 = read
- dbg_req_addr  in  AW  host register address
- dbg_req_wdata  in  DW  host write data
- dbg_rsp_valid  out  1  read data valid; the host must accept it
- dbg_rsp_rdata  out  DW  read data
- rf_ra_raddr, rf_rb_raddr, rf_rd_waddr  out  AW  address ports to the register file
- rf_rd_wdata  out  DW  write data to the register file
- rf_rd_wen  out  1  write enable to the register file
- rf_ra_rdata, rf_rb_rdata  in  DW  register file read data (registered address, 1-cycle latency)

## Operation
- FSM has two states: INIT and RUN. Reset enters INIT with fill counter = 0.
- INIT:
  - rf_rd_wen=1, rf_rd_waddr=counter, rf_rd_wdata=0.
  - Counter increments each cycle. After writing NREGS-1 → RUN.
  - core_stall=1, dbg_req_ready=0, init_done=0.
- RUN: init_done=1.
- Read A is always the core's: rf_ra_raddr=core_ra_raddr, core_ra_rdata=rf_ra_rdata.
- Host write grant: when core_rd_wen=0, or when forced.
- Host read grant: when core_rb_req=0, or when forced.
- dbg_req_ready = RUN && valid && grant condition for the request type. A transfer occurs on valid && ready.
- Granted write drives the rf write port with the host address and data. Otherwise core_rd_* pass through.
- Granted read drives rf_rb_raddr=dbg_req_addr. Otherwise rf_rb_raddr=core_rb_raddr.
- Starvation counter:
  - Increments on cycles with dbg_req_valid && !dbg_req_ready.
  - Clears on transfer or when valid is low.
  - When it equals STARVE_MAX: core_stall=1 for that cycle, the host is granted regardless of core requests, and the core write is suppressed.
- Read response: dbg_rsp_valid pulses 1 cycle after a read transfer, with dbg_rsp_rdata=rf_rb_rdata. Back-to-back reads are pipelined, one response per cycle.
- core_rb_rdata=rf_rb_rdata always. The value is meaningful to the core only in cycles following its own rb request.
- A host write to x0 is passed to the file. The file forces x0=0, so a read returns 0.

## Timing
- Reset values: init_done=0, core_stall=1, dbg_req_ready=0, dbg_rsp_valid=0, rf_rd_wen=1 (fill of entry 0), starvation counter=0.
- Zero-fill occupies exactly NREGS cycles. init_done rises in cycle NREGS after reset deassertion.
- dbg_req_ready is combinational from valid, we, core_rd_wen, core_rb_req and the starvation count. No request is held inside the block.
- Host read latency is 1 cycle (request accepted in cycle N, dbg_rsp_valid in cycle N+1).
- A forced grant costs the core exactly one stall cycle. The core must re-present its write or read the next cycle.
- Simultaneous core write and host write to the same address: the core wins unless forced. If forced, the host data is written.
- Reset asserted mid-fill or mid-read:
  - FSM returns to INIT and the fill restarts from 0.
  - A pending dbg_rsp_valid is dropped.

## Structure
- Package fwrisc_regfile_arb_pkg holds:
  - state enum {INIT, RUN}
  - default AW/DW/NREGS constants
- No sub-module. The FSM, fill counter and starvation counter are local.
- The block instantiates nothing. It sits between the core and the register file.

## Test plan
- Reset release, then read all 64 entries via the host. Expect init_done at cycle 64 and every rsp_rdata=0x00000000.
- Host write 0xDEADBEEF to x5 with core idle, then host read x5. Expect ready same cycle, rsp_valid the next cycle, data 0xDEADBEEF.
- Core writes every cycle while the host requests a write with STARVE_MAX=16. Expect ready=0 for 16 cycles, then core_stall=1 and ready=1 in the same cycle, the host data stored, and the core write dropped.
- Core and host write x7 in the same cycle with the core winning (core 0x11, host 0x22). Expect x7=0x11, then the host is granted the next idle cycle and x7=0x22.
- Three back-to-back host reads of x1, x2 and x3 (preloaded 1, 2, 3) with core_rb_req=0. Expect rsp_valid for 3 consecutive cycles with data 1, 2, 3.
- Assert reset at fill count 20, release. Expect the fill to restart at address 0 and init_done 64 cycles after release.
